// File: rtl/strided_be_gen_pkg.sv
// strided_be_pkg: shared types for the strided byte-enable generator.
//   sew_e      : element size encoding (8/16/32 bit, 3 = illegal)
//   be_state_e : controller states (IDLE, RUN, DONE)
//   esize()    : element size in bytes for a sew_e value
package strided_be_pkg;

  typedef enum logic [1:0] {
    SEW_8   = 2'd0,
    SEW_16  = 2'd1,
    SEW_32  = 2'd2,
    SEW_ILL = 2'd3
  } sew_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } be_state_e;

  // The illegal encoding maps to 1 so callers never divide by zero;
  // illegal requests are rejected before any beat is packed.
  function automatic int unsigned esize(sew_e sew);
    case (sew)
      SEW_16:  return 32'd2;
      SEW_32:  return 32'd4;
      default: return 32'd1;
    endcase
  endfunction

endpackage

// File: rtl/strided_be_gen_packer.sv
// be_packer: combinational beat packer.
// Starting at cur_addr_i, gathers elements cur, cur+stride, ... that share
// the same bus word, limited by remaining_i and BUS_BYTES/esize.
//   cur_addr_i    : address of the next unsent element
//   stride_i      : byte stride (two's complement, wraps mod 2^ADDR_W)
//   remaining_i   : elements still to send
//   sew_i         : element size
//   word_addr_o   : word-aligned beat address
//   mask_o        : byte enables of all packed elements
//   cnt_o         : number of packed elements
//   next_addr_o   : address of the first element not in this beat
module be_packer
  import strided_be_pkg::*;
#(
  parameter int unsigned BUS_BYTES = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned VL_W      = 5
) (
  input  logic [ADDR_W-1:0]    cur_addr_i,
  input  logic [ADDR_W-1:0]    stride_i,
  input  logic [VL_W-1:0]      remaining_i,
  input  sew_e                 sew_i,
  output logic [ADDR_W-1:0]    word_addr_o,
  output logic [BUS_BYTES-1:0] mask_o,
  output logic [VL_W-1:0]      cnt_o,
  output logic [ADDR_W-1:0]    next_addr_o
);

  localparam int unsigned OFS_W = $clog2(BUS_BYTES);

  function automatic logic [BUS_BYTES-1:0] elem_mask(logic [ADDR_W-1:0] a, int unsigned es);
    logic [BUS_BYTES-1:0] ones;
    ones = BUS_BYTES'((32'd1 << es) - 32'd1);
    return ones << a[OFS_W-1:0];
  endfunction

  int unsigned       es;
  int unsigned       max_el;
  logic [ADDR_W-1:0] run_addr;
  logic              packing;

  assign word_addr_o = {cur_addr_i[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};

  always_comb begin
    es          = esize(sew_i);
    max_el      = BUS_BYTES / es;
    mask_o      = '0;
    cnt_o       = '0;
    run_addr    = cur_addr_i;
    packing     = 1'b1;
    for (int unsigned k = 0; k < BUS_BYTES; k++) begin
      // Aligned elements never straddle a word, so a word-index match is enough.
      if (packing && (k < 32'(remaining_i)) && (k < max_el) &&
          (run_addr[ADDR_W-1:OFS_W] == cur_addr_i[ADDR_W-1:OFS_W])) begin
        mask_o   = mask_o | elem_mask(run_addr, es);
        cnt_o    = cnt_o + VL_W'(1);
        run_addr = run_addr + stride_i;
      end else begin
        packing = 1'b0;
      end
    end
    next_addr_o = run_addr;
    // Zero stride: every element hits the same bytes, so one beat covers them all.
    if (stride_i == '0) begin
      mask_o      = elem_mask(cur_addr_i, es);
      cnt_o       = remaining_i;
      next_addr_o = cur_addr_i;
    end
  end

endmodule

// File: rtl/strided_be_gen.sv
// strided_be_gen: turns (base, signed stride, vl, sew) into word-aligned
// bus beats with byte enables and element counts over valid/ready.
// Build option: STRIDED_BE_NEG_STRIDE_EN enables negative strides; when
// undefined a stride with its MSB set is rejected with done_o + err_o.
//
// state   | meaning
// IDLE    | waiting for start_i; request is captured and checked here
// RUN     | presenting beats; accepted last beat moves to DONE
// DONE    | one-cycle done_o (and err_o if rejected) pulse
//
// Ports: clk_i, n_rst_i (async active-low); request start_i, base_addr_i,
// stride_i, vl_i, sew_i; beat valid_o/ready_i with addr_o, be_o,
// elem_cnt_o, last_o; status busy_o, done_o, err_o.
module strided_be_gen
  import strided_be_pkg::*;
#(
  parameter int unsigned BUS_BYTES = 4,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned VL_W      = 5
) (
  input  logic                 clk_i,
  input  logic                 n_rst_i,
  input  logic                 start_i,
  input  logic [ADDR_W-1:0]    base_addr_i,
  input  logic [ADDR_W-1:0]    stride_i,
  input  logic [VL_W-1:0]      vl_i,
  input  logic [1:0]           sew_i,
  input  logic                 ready_i,
  output logic                 valid_o,
  output logic [ADDR_W-1:0]    addr_o,
  output logic [BUS_BYTES-1:0] be_o,
  output logic [VL_W-1:0]      elem_cnt_o,
  output logic                 last_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  be_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [VL_W-1:0]   rem_q, rem_d;
  sew_e              sew_q, sew_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0]    pk_word, pk_next;
  logic [BUS_BYTES-1:0] pk_mask;
  logic [VL_W-1:0]      pk_cnt;
  logic                 in_run, pk_last;
  logic [ADDR_W-1:0]    align_m;
  logic                 neg_bad, illegal;

  be_packer #(
    .BUS_BYTES (BUS_BYTES),
    .ADDR_W    (ADDR_W),
    .VL_W      (VL_W)
  ) u_packer (
    .cur_addr_i  (cur_q),
    .stride_i    (stride_q),
    .remaining_i (rem_q),
    .sew_i       (sew_q),
    .word_addr_o (pk_word),
    .mask_o      (pk_mask),
    .cnt_o       (pk_cnt),
    .next_addr_o (pk_next)
  );

  always_comb begin
    align_m = ADDR_W'(esize(sew_e'(sew_i)) - 32'd1);
`ifdef STRIDED_BE_NEG_STRIDE_EN
    neg_bad = 1'b0;
`else
    neg_bad = stride_i[ADDR_W-1];
`endif
    illegal = (sew_i == 2'd3) || (|(base_addr_i & align_m)) ||
              (|(stride_i & align_m)) || neg_bad;
  end

  assign in_run  = (state_q == ST_RUN);
  assign pk_last = (rem_q == pk_cnt);

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    stride_d = stride_q;
    rem_d    = rem_q;
    sew_d    = sew_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          cur_d    = base_addr_i;
          stride_d = stride_i;
          rem_d    = vl_i;
          sew_d    = sew_e'(sew_i);
          err_d    = illegal;
          state_d  = (illegal || (vl_i == '0)) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (ready_i) begin
          cur_d = pk_next;
          rem_d = rem_q - pk_cnt;
          if (pk_last) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      stride_q <= '0;
      rem_q    <= '0;
      sew_q    <= SEW_8;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      stride_q <= stride_d;
      rem_q    <= rem_d;
      sew_q    <= sew_d;
      err_q    <= err_d;
    end
  end

  // Beat fields are forced to zero outside RUN so idle/reset outputs read 0.
  assign valid_o    = in_run;
  assign addr_o     = in_run ? pk_word : '0;
  assign be_o       = in_run ? pk_mask : '0;
  assign elem_cnt_o = in_run ? pk_cnt  : '0;
  assign last_o     = in_run && pk_last;
  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = (state_q == ST_DONE);
  assign err_o      = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_strided_be_gen.sv
// Testbench for strided_be_gen (BUS_BYTES = 4). A request-level model
// expands each request into its element addresses and groups them into
// expected beats; one negedge process compares every valid beat.
module tb_strided_be_gen;

`ifdef STRIDED_BE_NEG_STRIDE_EN
  localparam bit NEG_EN = 1'b1;
`else
  localparam bit NEG_EN = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        n_rst_i;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [31:0] stride_i;
  logic [4:0]  vl_i;
  logic [1:0]  sew_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] addr_o;
  logic [3:0]  be_o;
  logic [4:0]  elem_cnt_o;
  logic        last_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  strided_be_gen #(.BUS_BYTES(4), .ADDR_W(32), .VL_W(5)) dut (
    .clk_i       (clk_i),
    .n_rst_i     (n_rst_i),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .stride_i    (stride_i),
    .vl_i        (vl_i),
    .sew_i       (sew_i),
    .ready_i     (ready_i),
    .valid_o     (valid_o),
    .addr_o      (addr_o),
    .be_o        (be_o),
    .elem_cnt_o  (elem_cnt_o),
    .last_o      (last_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [4:0]  cnt;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    last_acc_cyc = 0;
  bit    chk_en = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: element i sits at base + i*stride (mod 2^32). Walk the elements in
  // order, starting a new beat whenever the word changes or the beat is full.
  function automatic bit build(input logic [31:0] base, input logic [31:0] stride,
                               input logic [4:0] vl, input logic [1:0] sew);
    int unsigned es;
    int          i, n;
    logic [31:0] a, w;
    logic [3:0]  m;
    beat_t       b;
    es = (sew == 2'd1) ? 2 : (sew == 2'd2) ? 4 : 1;
    if (sew == 2'd3 || (base % es) != 0 || (stride % es) != 0 || (!NEG_EN && stride[31]))
      return 1'b1;
    if (vl == 5'd0) return 1'b0;
    if (stride == 32'd0) begin
      b.addr = base & ~32'h3;
      b.be   = 4'(((1 << es) - 1) << base[1:0]);
      b.cnt  = vl;
      b.last = 1'b1;
      exp_q.push_back(b);
      return 1'b0;
    end
    i = 0;
    while (i < int'(vl)) begin
      w = (base + 32'(i) * stride) & ~32'h3;
      m = 4'd0;
      n = 0;
      a = base + 32'(i) * stride;
      while (i < int'(vl) && n < int'(4 / es) && (a & ~32'h3) == w) begin
        m = m | 4'(((1 << es) - 1) << a[1:0]);
        n++;
        i++;
        a = base + 32'(i) * stride;
      end
      b.addr = w;
      b.be   = m;
      b.cnt  = 5'(n);
      b.last = (i == int'(vl));
      exp_q.push_back(b);
    end
    return 1'b0;
  endfunction

  always @(negedge clk_i) begin
    if (chk_en && n_rst_i && valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", valid_o, 1'b0);
      end else begin
        chk("beat_addr", addr_o, exp_q[0].addr);
        chk("beat_be", be_o, exp_q[0].be);
        chk("beat_cnt", elem_cnt_o, exp_q[0].cnt);
        chk("beat_last", last_o, exp_q[0].last);
        chk("busy_in_run", busy_o, 1'b1);
        if (ready_i) begin
          if (last_o) last_acc_cyc = cyc + 1;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic run_req(input string name, input logic [31:0] base, input logic [31:0] stride,
                         input logic [4:0] vl, input logic [1:0] sew, input int stall);
    bit exp_err;
    int nbeats, n_start, exp_done, t;
    exp_q.delete();
    exp_err = build(base, stride, vl, sew);
    nbeats  = exp_q.size();
    @(posedge clk_i);
    #1;
    start_i     = 1'b1;
    base_addr_i = base;
    stride_i    = stride;
    vl_i        = vl;
    sew_i       = sew;
    ready_i     = (stall == 0);
    @(posedge clk_i);
    #1;
    n_start = cyc;
    start_i = 1'b0;
    if (stall > 0) begin
      repeat (stall) @(posedge clk_i);
      #1;
      ready_i = 1'b1;
    end
    t = 0;
    while (t < 100) begin
      @(negedge clk_i);
      if (done_o) break;
      t++;
    end
    exp_done = (nbeats == 0) ? n_start : last_acc_cyc;
    chk({name, "_done_seen"}, done_o, 1'b1);
    chk({name, "_done_cycle"}, 64'(cyc), 64'(exp_done));
    chk({name, "_err"}, err_o, exp_err);
    chk({name, "_busy_in_done"}, busy_o, 1'b1);
    chk({name, "_beats_left"}, 64'(exp_q.size()), 64'd0);
    @(negedge clk_i);
    chk({name, "_done_pulse"}, done_o, 1'b0);
    chk({name, "_idle_busy"}, busy_o, 1'b0);
    exp_q.delete();
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_valid"}, valid_o, 1'b0);
    chk({name, "_addr"}, addr_o, 32'd0);
    chk({name, "_be"}, be_o, 4'd0);
    chk({name, "_cnt"}, elem_cnt_o, 5'd0);
    chk({name, "_last"}, last_o, 1'b0);
    chk({name, "_busy"}, busy_o, 1'b0);
    chk({name, "_done"}, done_o, 1'b0);
    chk({name, "_err"}, err_o, 1'b0);
  endtask

  initial begin
    n_rst_i     = 1'b0;
    start_i     = 1'b0;
    ready_i     = 1'b0;
    base_addr_i = 32'd0;
    stride_i    = 32'd0;
    vl_i        = 5'd0;
    sew_i       = 2'd0;
    repeat (2) @(negedge clk_i);
    chk_outputs_zero("reset");
    n_rst_i = 1'b1;
    chk_en  = 1'b1;

    // Pin the model against hand-computed beats.
    void'(build(32'h100, 32'd1, 5'd6, 2'd0));
    chk("pin_unit_n", 64'(exp_q.size()), 64'd2);
    chk("pin_unit_b0", {exp_q[0].addr, exp_q[0].be, exp_q[0].cnt, exp_q[0].last},
        {32'h100, 4'b1111, 5'd4, 1'b0});
    chk("pin_unit_b1", {exp_q[1].addr, exp_q[1].be, exp_q[1].cnt, exp_q[1].last},
        {32'h104, 4'b0011, 5'd2, 1'b1});
    exp_q.delete();
    void'(build(32'h102, 32'd2, 5'd3, 2'd0));
    chk("pin_s2_b0", {exp_q[0].addr, exp_q[0].be, exp_q[0].cnt}, {32'h100, 4'b0100, 5'd1});
    chk("pin_s2_b1", {exp_q[1].addr, exp_q[1].be, exp_q[1].cnt}, {32'h104, 4'b0101, 5'd2});
    exp_q.delete();
    void'(build(32'h303, 32'd0, 5'd5, 2'd0));
    chk("pin_s0_b0", {exp_q[0].addr, exp_q[0].be, exp_q[0].cnt}, {32'h300, 4'b1000, 5'd5});
    exp_q.delete();

    run_req("unit8",   32'h100,       32'd1,         5'd6, 2'd0, 0);
    run_req("stride2", 32'h102,       32'd2,         5'd3, 2'd0, 0);
    run_req("neg16",   32'h200,       32'hFFFF_FFFE, 5'd3, 2'd1, 0);
    run_req("stride0", 32'h303,       32'd0,         5'd5, 2'd0, 3);
    run_req("vl0",     32'h100,       32'd4,         5'd0, 2'd0, 0);
    run_req("misal32", 32'h102,       32'd4,         5'd2, 2'd2, 0);
    run_req("sew3",    32'h10,        32'd4,         5'd3, 2'd3, 0);
    run_req("w32",     32'h1000,      32'd8,         5'd3, 2'd2, 1);
    run_req("h16",     32'h102,       32'd2,         5'd4, 2'd1, 2);
    run_req("wrap",    32'hFFFF_FFFE, 32'd1,         5'd4, 2'd0, 0);

    // Reset while the second beat of the unit-stride request is on the bus.
    exp_q.delete();
    void'(build(32'h100, 32'd1, 5'd6, 2'd0));
    @(posedge clk_i);
    #1;
    start_i     = 1'b1;
    base_addr_i = 32'h100;
    stride_i    = 32'd1;
    vl_i        = 5'd6;
    sew_i       = 2'd0;
    ready_i     = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    @(posedge clk_i);
    #2;
    chk("mid_valid", valid_o, 1'b1);
    chk("mid_addr", addr_o, 32'h104);
    chk_en  = 1'b0;
    n_rst_i = 1'b0;
    #1;
    chk_outputs_zero("mid_rst");
    @(posedge clk_i);
    #1;
    chk_outputs_zero("mid_rst_held");
    @(negedge clk_i);
    n_rst_i = 1'b1;
    exp_q.delete();
    chk_en  = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk("post_rst_done", done_o, 1'b0);
      chk("post_rst_valid", valid_o, 1'b0);
    end
    run_req("after_rst", 32'h102, 32'd2, 5'd3, 2'd0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
